// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - OpenMIPS instruction-fetch stage: PC, ROM interface and IF/ID register
//
// Purpose:
//   Holds the program counter and drives the instruction ROM. Captures the
//   combinational ROM read data, with its PC, into the IF/ID pipeline
//   register. Handles stall, flush to an exception vector, and taken-branch
//   redirect with the delay-slot instruction kept. Counts accepted fetches.
//
// Optional feature macro: IF_MISALIGN_EXC_EN
//   When defined, a PC with nonzero low bits disables the ROM for that
//   cycle. The captured slot is then tagged with id_adel_o, so decode raises
//   an address-error exception.
//
// Ports:
//   clk             in   pipeline clock, rising edge
//   rst             in   asynchronous active-high reset
//   stall_pc_i      in   hold PC
//   stall_if_i      in   hold IF/ID register
//   stall_id_i      in   decode stage held
//   flush_i         in   exception/eret flush, highest priority
//   new_pc_i        in   flush redirect target
//   branch_flag_i   in   taken branch/jump resolved in ID
//   branch_target_i in   taken-branch target
//   rom_ce_o        out  ROM chip enable
//   rom_addr_o      out  ROM byte address (current PC)
//   rom_inst_i      in   ROM read data, combinational from rom_addr_o
//   id_pc_o         out  PC of instruction presented to ID
//   id_inst_o       out  instruction presented to ID
//   id_valid_o      out  id_inst_o is a real fetched instruction
//   fetch_cnt_o     out  instructions accepted into IF/ID, mod 2^32
//   id_adel_o       out  (IF_MISALIGN_EXC_EN only) misaligned fetch tag

module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32,
   parameter int          INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_pc_i,
   input  logic              stall_if_i,
   input  logic              stall_id_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] new_pc_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0] rom_inst_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_valid_o,
`ifdef IF_MISALIGN_EXC_EN
   output logic              id_adel_o,
`endif
   output logic [31:0]       fetch_cnt_o
);

   typedef enum logic {
      ST_OFF = 1'b0,
      ST_RUN = 1'b1
   } fetch_state_t;

   fetch_state_t      state;
   logic              ce_q;
   logic [ADDR_W-1:0] pc;
   logic              capture;
   logic              bubble;

   // Fetch enable FSM and PC. ce_q is the registered FSM output and is
   // high exactly while in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_OFF;
         ce_q  <= 1'b0;
         pc    <= ADDR_W'(RESET_PC);
      end else begin
         case (state)
            ST_OFF: begin
               state <= ST_RUN;
               ce_q  <= 1'b1;
            end
            ST_RUN: begin
               ce_q <= 1'b1;
               // A branch arriving during a PC stall is dropped here.
               // Upstream control holds branch_flag_i until the stall ends.
               if (flush_i)
                  pc <= new_pc_i;
               else if (stall_pc_i)
                  pc <= pc;
               else if (branch_flag_i)
                  pc <= branch_target_i;
               else
                  pc <= pc + ADDR_W'(4);
            end
            default: begin
               state <= ST_OFF;
               ce_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rom_addr_o = pc;

`ifdef IF_MISALIGN_EXC_EN
   logic misaligned;
   assign misaligned = ce_q & (pc[1:0] != 2'b00);
   assign rom_ce_o   = ce_q & ~misaligned;
`else
   // The ROM word-indexes the address, so pc[1:0] plays no part here.
   assign rom_ce_o = ce_q;
`endif

   // A new slot is loaded into IF/ID only when IF is not stalled and no
   // flush is in progress. A stall of IF alone (ID still moving) pushes a
   // bubble so the same instruction does not reach ID twice.
   assign capture = ~flush_i & ~stall_if_i;
   assign bubble  = flush_i | (stall_if_i & ~stall_id_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc_o    <= '0;
         id_inst_o  <= '0;
         id_valid_o <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
         id_adel_o  <= 1'b0;
`endif
      end else if (bubble) begin
         id_pc_o    <= '0;
         id_inst_o  <= '0;
         id_valid_o <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
         id_adel_o  <= 1'b0;
`endif
      end else if (capture) begin
         id_pc_o <= pc;
`ifdef IF_MISALIGN_EXC_EN
         if (misaligned) begin
            // Valid but empty slot: decode turns the tag into AdEL.
            id_inst_o  <= '0;
            id_valid_o <= 1'b1;
            id_adel_o  <= 1'b1;
         end else begin
            id_inst_o  <= rom_inst_i;
            id_valid_o <= rom_ce_o;
            id_adel_o  <= 1'b0;
         end
`else
         id_inst_o  <= rom_inst_i;
         id_valid_o <= rom_ce_o;
`endif
      end
   end

   // Counts only real ROM fetches loaded into IF/ID. Holds, bubbles and
   // flushes leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_cnt_o <= '0;
      else if (capture && rom_ce_o)
         fetch_cnt_o <= fetch_cnt_o + 32'd1;
   end

endmodule
